// File: rtl/key_step_iface_pkg.sv
// key_iface_pkg: shared types and default timing for the key/step front end.
//  step_state_t : step FSM states (REPEAT only reachable with KEY_REPEAT_EN)
//  KEY_*        : KEY pin index for each function
//  *_DEF        : default timing in CLOCK_50 cycles
package key_iface_pkg;
  typedef enum logic [1:0] {IDLE, HELD, REPEAT} step_state_t;

  localparam int KEY_STEP = 0;
  localparam int KEY_RST  = 1;
  localparam int KEY_S    = 2;
  localparam int KEY_LOAD = 3;

  localparam int unsigned DEBOUNCE_DEF      = 1_000_000;  // 20 ms @ 50 MHz
  localparam int unsigned REPEAT_DELAY_DEF  = 25_000_000;
  localparam int unsigned REPEAT_PERIOD_DEF = 5_000_000;
endpackage

// File: rtl/key_step_iface_if.sv
// key_step_if: board-side bundle between the DE1-SoC pins and the cpu.
//  key_n  raw KEY[3:0], 0 = pressed     sw    raw SW[9:0]
//  step   one-cycle step pulse          cpu_reset/s/load  debounced levels
//  ir     assembled instruction word    ledr  echo of the non-edited ir half
// Modports: slave = the front end block, master = whoever drives the pins.
interface key_step_if;
  logic [3:0]  key_n;
  logic [9:0]  sw;
  logic        step;
  logic        cpu_reset;
  logic        s;
  logic        load;
  logic [15:0] ir;
  logic [7:0]  ledr;

  modport slave  (input key_n, sw, output step, cpu_reset, s, load, ir, ledr);
  modport master (output key_n, sw, input step, cpu_reset, s, load, ir, ledr);
endinterface

// File: rtl/key_step_iface_debounce.sv
// key_debounce: one KEY pin -> 2-flop sync -> debounced pressed level.
//  clk, reset_n   clock, async active-low reset
//  i_key_n        raw pin, 0 = pressed
//  o_level        debounced pressed level (1 = pressed)
//  o_press        one-cycle pulse in the cycle o_level first reads pressed
// A change is accepted after DEBOUNCE_CYCLES consecutive cycles of the synced
// input disagreeing with the stable level; any agreement restarts the count.
module key_debounce
  import key_iface_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_DEF
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_key_n,
  output logic o_level,
  output logic o_press
);
  localparam int unsigned CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    r_sync;
  logic [CW-1:0] r_cnt;
  logic          r_level;
  logic          r_press;
  logic          w_pressed;

  assign w_pressed = ~r_sync[1];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync  <= 2'b11;  // released
      r_cnt   <= '0;
      r_level <= 1'b0;
      r_press <= 1'b0;
    end else begin
      r_sync  <= {r_sync[0], i_key_n};
      r_press <= 1'b0;
      if (w_pressed == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_LAST) begin
        r_level <= w_pressed;
        r_press <= w_pressed;
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_level = r_level;
  assign o_press = r_press;
endmodule

// File: rtl/key_step_iface.sv
// key_step_iface: DE1-SoC KEY/SW front end for the cpu.
//  clk      CLOCK_50
//  reset_n  async active-low system reset
//  bus      key_step_if.slave: key_n/sw in; step, cpu_reset, s, load, ir, ledr out
// KEY0 -> step pulse (clock enable), KEY1/2/3 -> cpu_reset/s/load levels.
// ir halves are written from sw[7:0], sw[9] picking the high half; ledr shows
// the other half.
// Optional: define KEY_REPEAT_EN for auto-repeat of step while KEY0 is held.
module key_step_iface
  import key_iface_pkg::*;
#(
`ifdef KEY_REPEAT_EN
  parameter int unsigned REPEAT_DELAY    = REPEAT_DELAY_DEF,
  parameter int unsigned REPEAT_PERIOD   = REPEAT_PERIOD_DEF,
`endif
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_DEF
) (
  input logic      clk,
  input logic      reset_n,
  key_step_if.slave bus
);
  logic [3:0]  w_level;
  logic [3:0]  w_press;
  logic [9:0]  r_sw_s1, r_sw_s2;
  logic [15:0] r_ir;
  logic        r_cpu_reset, r_s, r_load;
  step_state_t r_state, w_next;
  logic        w_step;

  for (genvar g = 0; g < 4; g++) begin : g_key
    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
      .clk     (clk),
      .reset_n (reset_n),
      .i_key_n (bus.key_n[g]),
      .o_level (w_level[g]),
      .o_press (w_press[g])
    );
  end

  // Levels registered one cycle after the stable update; cpu held in reset
  // for as long as the system reset is asserted.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cpu_reset <= 1'b1;
      r_s         <= 1'b0;
      r_load      <= 1'b0;
    end else begin
      r_cpu_reset <= w_level[KEY_RST];
      r_s         <= w_level[KEY_S];
      r_load      <= w_level[KEY_LOAD];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sw_s1 <= '0;
      r_sw_s2 <= '0;
      r_ir    <= '0;
    end else begin
      r_sw_s1 <= bus.sw;
      r_sw_s2 <= r_sw_s1;
      if (r_sw_s2[9]) r_ir[15:8] <= r_sw_s2[7:0];
      else            r_ir[7:0]  <= r_sw_s2[7:0];
    end
  end

`ifdef KEY_REPEAT_EN
  localparam int unsigned RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned RW   = (RMAX > 1) ? $clog2(RMAX) : 1;
  localparam logic [RW-1:0] RD_LAST = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] RP_LAST = RW'(REPEAT_PERIOD - 1);
  logic [RW-1:0] r_rep_cnt;
  logic          w_rep_wrap;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_next;
  end

  // Release is checked before any repeat so no pulse lands on the release cycle.
  always_comb begin
    w_next = r_state;
    w_step = 1'b0;
`ifdef KEY_REPEAT_EN
    w_rep_wrap = 1'b0;
`endif
    case (r_state)
      IDLE: if (w_press[KEY_STEP]) begin
        w_next = HELD;
        w_step = 1'b1;
      end
      HELD: begin
        if (!w_level[KEY_STEP]) w_next = IDLE;
`ifdef KEY_REPEAT_EN
        else if (r_rep_cnt == RD_LAST) begin
          w_next = REPEAT;
          w_step = 1'b1;
        end
      end
      REPEAT: begin
        if (!w_level[KEY_STEP]) w_next = IDLE;
        else if (r_rep_cnt == RP_LAST) begin
          w_step     = 1'b1;
          w_rep_wrap = 1'b1;
        end
`endif
      end
      default: w_next = IDLE;
    endcase
  end

`ifdef KEY_REPEAT_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                             r_rep_cnt <= '0;
    else if (w_next != r_state || w_rep_wrap) r_rep_cnt <= '0;
    else if (r_state != IDLE)                 r_rep_cnt <= r_rep_cnt + 1'b1;
  end
`endif

  assign bus.step      = w_step;
  assign bus.cpu_reset = r_cpu_reset;
  assign bus.s         = r_s;
  assign bus.load      = r_load;
  assign bus.ir        = r_ir;
  assign bus.ledr      = r_sw_s2[9] ? r_ir[7:0] : r_ir[15:8];
endmodule

// File: tb/tb_key_step_iface.sv
// tb_key_step_iface: directed bench for key_step_iface with short timing
// (DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_PERIOD=8).
// Inputs change on negedge; outputs sampled on negedge. Step pulses are logged
// with the posedge count so latencies can be checked against hand values.
module tb_key_step_iface;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   steps[$];

  key_step_if bus();

  key_step_iface #(
`ifdef KEY_REPEAT_EN
    .REPEAT_DELAY(20), .REPEAT_PERIOD(8),
`endif
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (bus.step) steps.push_back(cyc);

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic int step_at(input int i);
    return (i < steps.size()) ? steps[i] : -1;
  endfunction

  initial begin
    int f, r, k;
    bus.key_n = 4'h0;
    bus.sw    = 10'h000;
    tick(3);
    // 1: reset with keys pressed
    chk("rst_ir", bus.ir, 16'h0000);
    chk("rst_step", bus.step, 0);
    chk("rst_s", bus.s, 0);
    chk("rst_load", bus.load, 0);
    chk("rst_cpu_reset", bus.cpu_reset, 1);
    bus.key_n = 4'hF;
    reset_n   = 1'b1;
    k = 0;
    while (bus.cpu_reset && k < 7) begin tick(1); k++; end
    chk("rst_release", bus.cpu_reset, 0);
    tick(4);

    // 2: short glitch, then a clean press
    steps.delete();
    bus.key_n[0] = 1'b0; tick(3);
    bus.key_n[0] = 1'b1; tick(12);
    chk("glitch_steps", steps.size(), 0);
    steps.delete();
    f = cyc;
    bus.key_n[0] = 1'b0; tick(10);
    bus.key_n[0] = 1'b1; tick(12);
    chk("press_steps", steps.size(), 1);
    chk("press_latency", step_at(0) - f, 6);

    // 3: bouncing press
    steps.delete();
    for (int i = 0; i < 6; i++) begin bus.key_n[0] = i[0]; tick(1); end
    bus.key_n[0] = 1'b0; tick(10);
    bus.key_n[0] = 1'b1; tick(12);
    chk("bounce_steps", steps.size(), 1);

    // 4: ir assembly and ledr echo
    bus.sw = 10'h2A5; tick(5);
    bus.sw = 10'h03C; tick(4);
    chk("ir_a53c", bus.ir, 16'hA53C);
    chk("ledr_hi", bus.ledr, 8'hA5);
    bus.sw = 10'h23C; tick(4);
    chk("ir_3c3c", bus.ir, 16'h3C3C);
    chk("ledr_lo", bus.ledr, 8'h3C);

    // 5: KEY2+KEY3 together (KEY0 held too), reset mid-hold
    steps.delete();
    f = cyc;
    bus.key_n = 4'b0010;
    k = 0;
    while (!bus.s && !bus.load && k < 12) begin tick(1); k++; end
    chk("s_rise", bus.s, 1);
    chk("load_rise", bus.load, 1);
    chk("s_latency", cyc - f, 7);
    tick(3);
    reset_n = 1'b0; #1;
    chk("midrst_s", bus.s, 0);
    chk("midrst_load", bus.load, 0);
    chk("midrst_cpu_reset", bus.cpu_reset, 1);
    tick(1);
    reset_n = 1'b1;
    r = cyc;
    tick(6);
    chk("rehold_s_early", bus.s, 0);
    tick(1);
    chk("rehold_s", bus.s, 1);
    chk("rehold_load", bus.load, 1);
    tick(1);
    bus.key_n = 4'hF; tick(12);
    chk("rehold_steps", steps.size(), 2);
    chk("rehold_step_lat", step_at(1) - r, 6);

    // 6: long hold of KEY0
    steps.delete();
    f = cyc;
    bus.key_n[0] = 1'b0; tick(60);
    bus.key_n[0] = 1'b1; tick(15);
`ifdef KEY_REPEAT_EN
    chk("hold_steps", steps.size(), 6);
    chk("hold_first", step_at(0) - f, 6);
    chk("hold_delay", step_at(1) - step_at(0), 20);
    chk("hold_period", step_at(2) - step_at(1), 8);
    chk("hold_period_last", step_at(5) - step_at(4), 8);
`else
    chk("hold_steps", steps.size(), 1);
    chk("hold_first", step_at(0) - f, 6);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
